// File: rtl/bpred_pkg.sv
// Shared types and saturating-counter helpers for the bpred_gshare direction predictor.
package bpred_pkg;

  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  localparam int          CTR_W_DEF = 2;
  localparam logic [31:0] CTR_MAX   = (32'd1 << CTR_W_DEF) - 32'd1;

  function automatic logic [31:0] ctr_max(input int ctr_w);
    return (32'd1 << ctr_w) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int ctr_w);
    return (v >= ctr_max(ctr_w)) ? ctr_max(ctr_w) : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v, input int ctr_w);
    return (v == 32'd0) ? 32'd0 : ((v - 32'd1) & ctr_max(ctr_w));
  endfunction

endpackage

// File: rtl/bpred_pht.sv
// Pattern history table: counters with async read, saturating update port and
// a one-entry-per-cycle initialisation sweep.
module bpred_pht
  import bpred_pkg::*;
#(
  parameter int IDX_W    = 8,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init,
  output logic             o_last,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0] o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] r_tbl [DEPTH];
  logic [IDX_W-1:0] r_ptr;
  logic [CTR_W-1:0] w_cur;
  logic [CTR_W-1:0] w_nxt;

  assign o_rd_ctr = r_tbl[i_rd_idx];
  assign w_cur    = r_tbl[i_wr_idx];
  assign w_nxt    = i_wr_taken ? CTR_W'(sat_inc(32'(w_cur), CTR_W))
                               : CTR_W'(sat_dec(32'(w_cur), CTR_W));
  assign o_last   = (r_ptr == {IDX_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_init) begin
      r_ptr <= r_ptr + IDX_W'(1);
    end
  end

  // Table is left unreset on purpose; the sweep owns initialisation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (i_init) begin
        r_tbl[r_ptr] <= CTR_W'(CTR_INIT);
      end else if (i_wr_en) begin
        r_tbl[i_wr_idx] <= w_nxt;
      end
    end
  end

endmodule

// File: rtl/bpred_gshare.sv
// Branch direction predictor top: INIT/RUN FSM, index hash and global history.
// Define GSHARE_EN for the gshare hash with speculative history; otherwise bimodal.
module bpred_gshare
  import bpred_pkg::*;
#(
  parameter int IDX_W    = 8,
  parameter int CTR_W    = 2,
  parameter int HIST_W   = 8,
  parameter int CTR_INIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_mispred
);

  bp_state_e        r_state;
  bp_state_e        w_state_nxt;
  logic             w_last;
  logic             w_run;
  logic [IDX_W-1:0] w_idx;
  logic [CTR_W-1:0] w_ctr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= BP_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BP_INIT: if (w_last) w_state_nxt = BP_RUN;
      BP_RUN:  w_state_nxt = BP_RUN;
      default: w_state_nxt = BP_INIT;
    endcase
  end

  assign w_run      = (r_state == BP_RUN);
  assign ready      = w_run;
  assign pred_taken = w_run & w_ctr[CTR_W-1];
  assign pred_idx   = w_idx;

`ifdef GSHARE_EN
  logic [HIST_W-1:0] r_ghr;
  logic [HIST_W:0]   w_spec;
  logic [HIST_W:0]   w_rcv;
  logic              w_unused_bits;

  assign w_spec = {r_ghr, pred_taken};
  assign w_rcv  = {upd_hist, upd_taken};

  // Recovery wins over a same-cycle shift: the younger lookup is being flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_run) begin
      if (upd_valid && upd_mispred) r_ghr <= w_rcv[HIST_W-1:0];
      else if (pred_valid)          r_ghr <= w_spec[HIST_W-1:0];
    end
  end

  assign w_idx         = pred_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign pred_hist     = r_ghr;
  assign w_unused_bits = ^{w_spec[HIST_W], w_rcv[HIST_W], pred_pc[31:IDX_W+2], pred_pc[1:0]};
`else
  logic w_unused_bits;

  assign w_idx         = pred_pc[IDX_W+1:2];
  assign pred_hist     = '0;
  assign w_unused_bits = ^{pred_valid, upd_hist, upd_mispred, pred_pc[31:IDX_W+2], pred_pc[1:0]};
`endif

  bpred_pht #(
    .IDX_W    (IDX_W),
    .CTR_W    (CTR_W),
    .CTR_INIT (CTR_INIT)
  ) u_pht (
    .clk        (clk),
    .rst        (rst),
    .i_init     (r_state == BP_INIT),
    .o_last     (w_last),
    .i_rd_idx   (w_idx),
    .o_rd_ctr   (w_ctr),
    .i_wr_en    (upd_valid && w_run),
    .i_wr_idx   (upd_idx),
    .i_wr_taken (upd_taken)
  );

endmodule

// File: doc/bpred_gshare.md
# bpred_gshare

Parametrised conditional-branch direction predictor for the 5-stage pipeline, replacing the fixed 256-entry, 2-bit inline history table. It is looked up in ID alongside decode and updated from EX branch resolution. It adds configurable table depth and counter width, true saturating counters, and an optional gshare global-history index hash with speculative history and mispredict recovery. It also adds a sequential table-initialisation sweep, so that large tables need no single-cycle reset loop.

## Interface

Parameters:

- IDX_W, default 8: table index width; the table holds 2^IDX_W entries.
- CTR_W, default 2: counter width. Prediction is the counter MSB.
- HIST_W, default 8: global history length; must satisfy 1 ≤ HIST_W ≤ IDX_W.
- CTR_INIT, default 1: counter value loaded by the init sweep (weakly not-taken).

Ports:

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the init sweep completes.
- pred_valid  in  1  an ID-stage branch is being looked up this cycle (branch, not stalled, not flushed).
- pred_pc  in  32  PC of the ID-stage instruction.
- pred_taken  out  1  predicted direction.
- pred_idx  out  IDX_W  table index used; carried down the pipeline to EX.
- pred_hist  out  HIST_W  global history snapshot before this lookup; carried to EX.
- upd_valid  in  1  EX has resolved a conditional branch.
- upd_idx  in  IDX_W  pred_idx carried with that branch.
- upd_hist  in  HIST_W  pred_hist carried with that branch.
- upd_taken  in  1  actual outcome.
- upd_mispred  in  1  direction was mispredicted; only meaningful when upd_valid is high.

## Operation

- States: INIT and RUN.
- rst forces INIT, sweep pointer = 0, ghr = 0, ready = 0. This applies in any state, including mid-sweep, which restarts the sweep from 0.
- INIT:
  - Each cycle writes CTR_INIT to entry[ptr] and increments ptr.
  - When ptr = 2^IDX_W−1 has been written, go to RUN and set ready = 1.
  - pred_valid and upd_valid are ignored, ghr does not change, and pred_taken = 0.
- Index: idx = pred_pc[IDX_W+1:2] XOR zero-extend(ghr). PC bits [1:0] are never used.
- Lookup: pred_taken = entry[idx][CTR_W−1], pred_idx = idx, pred_hist = ghr. All are combinational, with an asynchronous table read.
- Speculative history: in RUN, pred_valid shifts ghr to {ghr[HIST_W−2:0], pred_taken}.
- Counter update: in RUN, upd_valid modifies entry[upd_idx]:
  - taken: +1, saturating at 2^CTR_W−1;
  - not taken: −1, saturating at 0;
  - never wraps.
- Recovery: upd_valid && upd_mispred loads ghr with {upd_hist[HIST_W−2:0], upd_taken}. Recovery has priority over a same-cycle pred_valid shift, because the younger instruction is being flushed.
- Same cycle lookup and update to the same index: the lookup returns the pre-update value (read-before-write).
- upd_mispred without upd_valid: ignored.

## Timing

- Reset values: ready 0, ghr 0, state INIT, ptr 0. pred_taken is 0 while not ready.
- Init takes exactly 2^IDX_W cycles after rst deasserts. ready rises in the cycle after the last entry is written.
- Lookup latency: 0 cycles (combinational from pred_pc and state).
- Table writes and ghr changes become visible in the following cycle.
- One lookup and one update are supported per cycle, with no back-pressure.

## Configuration

- GSHARE_EN defined:
  - the ghr register, speculative shift and recovery are built;
  - the index uses the XOR hash.
- GSHARE_EN undefined:
  - pure bimodal predictor, with idx = pred_pc[IDX_W+1:2];
  - no ghr register;
  - pred_hist is driven to 0;
  - upd_hist and upd_mispred are ignored for history purposes;
  - counter update is unchanged.

## Structure

- Package bpred_pkg holds:
  - state enum BP_INIT/BP_RUN;
  - saturating increment/decrement functions parametrised by CTR_W;
  - localparam CTR_MAX.
- One sub-module, bpred_pht, contains:
  - the counter table and its asynchronous read port;
  - the saturating write port;
  - the init sweep pointer.
- The top level holds the FSM, the ghr and the index hash.

## Test plan

All scenarios use IDX_W=8, CTR_W=2, HIST_W=8, CTR_INIT=1.

1. **Reset and init:** pulse rst for 1 cycle → ready low for exactly 256 cycles, then high; pred_taken = 0 for every pred_pc throughout; updates during INIT leave entries at 1.
2. **Saturation:** 3 taken updates to idx 0x10 → counter 3 and pred_taken = 1; a 4th taken update keeps it at 3; 4 not-taken updates → 0; a 5th keeps 0 (no wrap to 3).
3. **Speculative history:** starting from ghr 0x00, three pred_valid lookups predicting 1, 0, 1 → pred_hist reads 0x00, 0x01, 0x02 and final ghr = 0x05.
4. **Mispredict recovery:** same cycle upd_valid = 1, upd_mispred = 1, upd_hist = 0x3C, upd_taken = 1, pred_valid = 1 → next-cycle ghr = 0x79 (the pred_valid shift is discarded).
5. **Hashing:** pred_pc 0x0000_0040 with ghr 0x0F → pred_idx 0x1F. Without GSHARE_EN → pred_idx 0x10 and pred_hist 0x00.
6. **Boundaries:**
   - Lookup and update on the same index in the same cycle → old pred_taken, with the new value in the next cycle.
   - rst asserted at sweep cycle 100 → ready stays low for a further 256 cycles.
